// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs and pipe-register strobes.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [REG_W-1:0] ex_rt_i;
    logic             branch_taken_i;
    logic             mem_busy_i;
    logic             pc_write_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_stall_o;
    logic             id_ex_flush_o;
    logic             ex_mem_stall_o;
    logic             mem_wb_flush_o;
    logic             err_o;
    logic [1:0]       state_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i,
        output ex_rt_i, branch_taken_i, mem_busy_i,
        input  pc_write_o, if_id_stall_o, if_id_flush_o,
        input  id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o,
        input  mem_wb_flush_o, err_o, state_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i,
        input  ex_rt_i, branch_taken_i, mem_busy_i,
        output pc_write_o, if_id_stall_o, if_id_flush_o,
        output id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o,
        output mem_wb_flush_o, err_o, state_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory waits.
// Optional HAZARD_STATS_EN adds stall_cycles_o / flush_count_o counters.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2,
        ERROR     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             lu;
    logic             at_limit;

    logic             pc_write, if_id_stall, if_id_flush;
    logic             id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;

    assign id_rs = hz.id_rs_i;
    assign id_rt = hz.id_rt_i;
    assign ex_rt = hz.ex_rt_i;

    assign lu = hz.ex_memread_i && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (hz.id_uses_rt_i && (ex_rt == id_rt)));

    assign at_limit = (wait_cnt_q >= 8'(MAX_WAIT));

    // State, wait counter and sticky error register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next state: busy beats load-use beats branch; bubble masks load-use
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            ERROR: begin
                state_d = ERROR;
            end
            MEM_WAIT: begin
                if (hz.mem_busy_i) begin
                    if (at_limit) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = lu ? LU_BUBBLE : RUN;
                end
            end
            LU_BUBBLE: begin
                if (hz.mem_busy_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                if (hz.mem_busy_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (lu) begin
                    state_d = LU_BUBBLE;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    // Strobe decode: zero-latency from current state and inputs
    always_comb begin
        pc_write     = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst_i) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state_q == ERROR) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (hz.mem_busy_i) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (lu && (state_q != LU_BUBBLE)) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (hz.branch_taken_i) begin
            if_id_flush  = 1'b1;
        end
    end

    assign hz.pc_write_o     = pc_write;
    assign hz.if_id_stall_o  = if_id_stall;
    assign hz.if_id_flush_o  = if_id_flush;
    assign hz.id_ex_stall_o  = id_ex_stall;
    assign hz.id_ex_flush_o  = id_ex_flush;
    assign hz.ex_mem_stall_o = ex_mem_stall;
    assign hz.mem_wb_flush_o = mem_wb_flush;
    assign hz.err_o          = err_q;
    assign hz.state_o        = state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating stall / IF_ID flush counters, excluded during reset
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vectors, expected values queued,
// monitor compares strobes/state/err every cycle at the falling edge.
module tb_hazard_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    hazard_ctrl_if #(.REG_W(5)) hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
`endif

    hazard_ctrl #(.REG_W(5), .MAX_WAIT(15)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
`endif
    );

    // strobe order: pc, if_stall, if_flush, idex_stall, idex_flush, exmem_stall, memwb_flush
    localparam logic [6:0] DEF = 7'b1000000;
    localparam logic [6:0] RST = 7'b0010101;
    localparam logic [6:0] LUS = 7'b0100100;
    localparam logic [6:0] BRF = 7'b1010000;
    localparam logic [6:0] FRZ = 7'b0101011;
    localparam logic [6:0] ERS = 7'b0101010;

    typedef struct {
        string      name;
        logic [6:0] s;
        logic [1:0] st;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic vec(input string n, input bit r, input int rs, input int rt,
                       input bit u, input bit mr, input int ert, input bit br,
                       input bit bz, input logic [6:0] s, input logic [1:0] st,
                       input bit e);
        exp_t x;
        @(posedge clk_i);
        #1;
        rst_i             = r;
        hz.id_rs_i        = 5'(rs);
        hz.id_rt_i        = 5'(rt);
        hz.id_uses_rt_i   = u;
        hz.ex_memread_i   = mr;
        hz.ex_rt_i        = 5'(ert);
        hz.branch_taken_i = br;
        hz.mem_busy_i     = bz;
        x.name = n;
        x.s    = s;
        x.st   = st;
        x.e    = e;
        exp_q.push_back(x);
    endtask

    task automatic idle(input string n, input logic [1:0] st, input bit e);
        vec(n, 0, 0, 0, 0, 0, 0, 0, 0, DEF, st, e);
    endtask

    // Monitor: one pop-and-compare per cycle with a pending expectation
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [6:0] got;
            x = exp_q.pop_front();
            got = {hz.pc_write_o, hz.if_id_stall_o, hz.if_id_flush_o,
                   hz.id_ex_stall_o, hz.id_ex_flush_o, hz.ex_mem_stall_o,
                   hz.mem_wb_flush_o};
            checks++;
            if (got !== x.s || hz.state_o !== x.st || hz.err_o !== x.e) begin
                failures++;
                $display("FAIL %s: got strobes=%b state=%0d err=%b, want strobes=%b state=%0d err=%b",
                         x.name, got, hz.state_o, hz.err_o, x.s, x.st, x.e);
            end
        end
    end

    // Hard time bound so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic drain;
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        hz.id_rs_i        = '0;
        hz.id_rt_i        = '0;
        hz.id_uses_rt_i   = 1'b0;
        hz.ex_memread_i   = 1'b0;
        hz.ex_rt_i        = '0;
        hz.branch_taken_i = 1'b0;
        hz.mem_busy_i     = 1'b0;
        repeat (2) @(posedge clk_i);

        vec("reset", 1, 0, 0, 0, 0, 0, 0, 0, RST, 2'd0, 0);
        idle("run_idle", 2'd0, 0);

        // load-use on rs, held into the bubble cycle
        vec("lu_rs", 0, 8, 0, 0, 1, 8, 0, 0, LUS, 2'd0, 0);
        vec("lu_bubble_mask", 0, 8, 0, 0, 1, 8, 0, 0, DEF, 2'd1, 0);
        idle("lu_back_run", 2'd0, 0);

        // rt match only counts when rt is read
        vec("rt_unused", 0, 1, 8, 0, 1, 8, 0, 0, DEF, 2'd0, 0);
        vec("rt_used", 0, 1, 8, 1, 1, 8, 0, 0, LUS, 2'd0, 0);
        idle("rt_bubble", 2'd1, 0);
        vec("zero_dest", 0, 0, 0, 1, 1, 0, 0, 0, DEF, 2'd0, 0);

        // branch alone, then branch with load-use
        vec("branch", 0, 0, 0, 0, 0, 0, 1, 0, BRF, 2'd0, 0);
        idle("after_branch", 2'd0, 0);
        vec("lu_and_branch", 0, 3, 0, 0, 1, 3, 1, 0, LUS, 2'd0, 0);
        vec("bubble_branch", 0, 0, 0, 0, 0, 0, 1, 0, BRF, 2'd1, 0);

        // busy beats load-use
        vec("busy_and_lu", 0, 3, 0, 0, 1, 3, 0, 1, FRZ, 2'd0, 0);
        idle("busy_lu_drop", 2'd2, 0);
        idle("busy_lu_run", 2'd0, 0);

        // three-cycle memory wait
        vec("wait1", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd0, 0);
        vec("wait2", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd2, 0);
        vec("wait3", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd2, 0);
        idle("wait_drop", 2'd2, 0);
        idle("wait_done", 2'd0, 0);

        // busy arriving in the bubble, branch honoured on the drop cycle
        vec("lu_pre_busy", 0, 5, 0, 0, 1, 5, 0, 0, LUS, 2'd0, 0);
        vec("bubble_busy", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd1, 0);
        vec("drop_branch", 0, 0, 0, 0, 0, 0, 1, 0, BRF, 2'd2, 0);
        idle("drop_branch_run", 2'd0, 0);

        // reset in the middle of a wait
        vec("midwait1", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd0, 0);
        vec("midwait2", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd2, 0);
        vec("midwait_rst", 1, 0, 0, 0, 0, 0, 0, 1, RST, 2'd2, 0);
        idle("midwait_run", 2'd0, 0);

        // timeout: 16 busy cycles lock the pipe
        vec("to_busy1", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd0, 0);
        for (int i = 2; i <= 16; i++) begin
            vec($sformatf("to_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd2, 0);
        end
        vec("err_lock_a", 0, 4, 0, 0, 1, 4, 1, 0, ERS, 2'd3, 1);
        vec("err_lock_b", 0, 0, 0, 0, 0, 0, 0, 1, ERS, 2'd3, 1);
        vec("err_rst", 1, 0, 0, 0, 0, 0, 0, 0, RST, 2'd3, 1);
        idle("err_cleared", 2'd0, 0);
        drain();

`ifdef HAZARD_STATS_EN
        vec("st_rst", 1, 0, 0, 0, 0, 0, 0, 0, RST, 2'd0, 0);
        vec("st_lu", 0, 8, 0, 0, 1, 8, 0, 0, LUS, 2'd0, 0);
        idle("st_bubble", 2'd1, 0);
        vec("st_w1", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd0, 0);
        vec("st_w2", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd2, 0);
        vec("st_w3", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 2'd2, 0);
        idle("st_drop", 2'd2, 0);
        vec("st_br1", 0, 0, 0, 0, 0, 0, 1, 0, BRF, 2'd0, 0);
        vec("st_br2", 0, 0, 0, 0, 0, 0, 1, 0, BRF, 2'd0, 0);
        idle("st_end", 2'd0, 0);
        drain();
        @(posedge clk_i);
        #1;
        checks++;
        if (stall_cycles_o !== 32'd4 || flush_count_o !== 16'd2) begin
            failures++;
            $display("FAIL stats: got stall=%0d flush=%0d, want stall=4 flush=2",
                     stall_cycles_o, flush_count_o);
        end
        vec("st_clr", 1, 0, 0, 0, 0, 0, 0, 0, RST, 2'd0, 0);
        idle("st_after_clr", 2'd0, 0);
        drain();
        #1;
        checks++;
        if (stall_cycles_o !== 32'd0 || flush_count_o !== 16'd0) begin
            failures++;
            $display("FAIL stats_clr: got stall=%0d flush=%0d, want 0 0",
                     stall_cycles_o, flush_count_o);
        end
`endif

        @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
